// File: rtl/maxnet_engine_if.sv
// Stream and result handshake bundle for maxnet_engine.
// The engine uses the slave modport; a producer/consumer uses master.
interface maxnet_engine_if #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned MAX_ITER = 255
) ();
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(MAX_ITER + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  max_value;
  logic [IW-1:0] max_index;
  logic [CW-1:0] iterations;
  logic          winner_valid;
  logic          timeout;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, max_value, max_index, iterations, winner_valid, timeout
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, max_value, max_index, iterations, winner_valid, timeout
  );
endinterface

// File: rtl/maxnet_engine.sv
// MaxNet winner-take-all engine: loads N samples serially, iterates lateral
// inhibition until at most one channel is non-zero or the cap is hit, then
// presents the winner over a valid/ready result handshake.
module maxnet_engine #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [FRAC-1:0] eps,
  maxnet_engine_if.slave  bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(MAX_ITER + 1);
  localparam int unsigned SW = W + $clog2(N);
  localparam int unsigned PW = SW + FRAC;
  localparam logic [IW:0]   NzOne   = {{IW{1'b0}}, 1'b1};
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);
  localparam logic [CW-1:0] IterCap = CW'(MAX_ITER);

  typedef enum logic [1:0] {StLoad, StIter, StDone} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  cnt_q;
  logic [CW-1:0]  iter_q;
  logic [FRAC-1:0] eps_q;
  logic [W-1:0]   x_q    [N];
  logic [W-1:0]   xo_q   [N];

  logic [W-1:0]   res_val_q;
  logic [IW-1:0]  res_idx_q;
  logic [CW-1:0]  res_iter_q;
  logic           res_wv_q;
  logic           res_tout_q;

  logic           load_fire;
  logic           load_last;
  logic           few_nz;
  logic           at_cap;
  logic [W-1:0]   clamped;

  logic [SW-1:0]  sum;
  logic [IW:0]    nz_cnt;
  logic [IW-1:0]  nz_idx;
  logic [IW-1:0]  arg_idx;
  logic [W-1:0]   best;
  logic [SW-1:0]  rest   [N];
  logic [PW-1:0]  prod   [N];
  logic [SW-1:0]  dec    [N];
  logic [W-1:0]   x_upd  [N];

  assign bus.in_ready     = (state_q == StLoad);
  assign bus.out_valid    = (state_q == StDone);
  assign bus.max_value    = res_val_q;
  assign bus.max_index    = res_idx_q;
  assign bus.iterations   = res_iter_q;
  assign bus.winner_valid = res_wv_q;
  assign bus.timeout      = res_tout_q;

  assign load_fire = bus.in_valid && (state_q == StLoad);
  assign load_last = (cnt_q == LastIdx);
  assign few_nz    = (nz_cnt <= NzOne);
  assign at_cap    = (iter_q == IterCap);
  assign clamped   = bus.in_data[W-1] ? '0 : bus.in_data;

  // Channel statistics on current contents plus the parallel inhibition update.
  // All x values are non-negative, so everything is handled as unsigned.
  always_comb begin
    sum     = '0;
    nz_cnt  = '0;
    nz_idx  = '0;
    arg_idx = '0;
    best    = x_q[0];
    for (int unsigned i = 0; i < N; i++) begin
      sum = sum + SW'(x_q[i]);
      if (x_q[i] != '0) begin
        nz_cnt = nz_cnt + NzOne;
        nz_idx = IW'(i);
      end
      // Strict compare keeps the lowest index among equal maxima.
      if (x_q[i] > best) begin
        best    = x_q[i];
        arg_idx = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      rest[i]  = sum - SW'(x_q[i]);
      prod[i]  = PW'(rest[i]) * PW'(eps_q);
      dec[i]   = SW'(prod[i] >> FRAC);
      x_upd[i] = (dec[i] >= SW'(x_q[i])) ? '0 : W'(SW'(x_q[i]) - dec[i]);
    end
  end

  // Controller next-state; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: if (load_fire && load_last) state_d = StIter;
      StIter: if (few_nz || at_cap) state_d = StDone;
      StDone: if (bus.out_ready) state_d = StLoad;
      default: state_d = StLoad;
    endcase
    if (clear) state_d = StLoad;
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StLoad;
    else      state_q <= state_d;
  end

  // Sample storage, iteration datapath and result capture on DONE entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      iter_q     <= '0;
      eps_q      <= '0;
      res_val_q  <= '0;
      res_idx_q  <= '0;
      res_iter_q <= '0;
      res_wv_q   <= 1'b0;
      res_tout_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        x_q[i]  <= '0;
        xo_q[i] <= '0;
      end
    end else if (clear) begin
      cnt_q      <= '0;
      iter_q     <= '0;
      res_val_q  <= '0;
      res_idx_q  <= '0;
      res_iter_q <= '0;
      res_wv_q   <= 1'b0;
      res_tout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (load_fire) begin
            x_q[cnt_q]  <= clamped;
            xo_q[cnt_q] <= clamped;
            if (load_last) begin
              cnt_q  <= '0;
              eps_q  <= eps;
              iter_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StIter: begin
          if (few_nz) begin
            res_wv_q   <= (nz_cnt == NzOne);
            res_idx_q  <= (nz_cnt == NzOne) ? nz_idx : '0;
            res_val_q  <= (nz_cnt == NzOne) ? xo_q[nz_idx] : '0;
            res_iter_q <= iter_q;
            res_tout_q <= 1'b0;
          end else if (at_cap) begin
            res_wv_q   <= 1'b1;
            res_idx_q  <= arg_idx;
            res_val_q  <= xo_q[arg_idx];
            res_iter_q <= iter_q;
            res_tout_q <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < N; i++) x_q[i] <= x_upd[i];
            iter_q <= iter_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
